// File: rtl/temp_sensor_reader.sv
// temp_sensor_reader
// Polls up to eight MAX6630-type temperature sensors that share one serial
// clock (SCK) and one data line (SO). Each has its own active-low chip select.
// Each frame is timed as follows:
//   CS setup (C_CS_SETUP cycles)
//   C_TEMP_SENSOR_PO_WL SCK high/low pairs (C_SCK_DIV cycles per half-period)
//   an inter-frame gap with every CS high (C_CS_SETUP cycles)
//   one STORE cycle
// At defaults a frame is 145 cycles. SO is sampled on every rising SCK edge,
// MSB first.
//
// Optional feature: define TEMP_SENSOR_ALARM_EN to add a signed over-threshold
// comparator per channel. When the macro is undefined, Alarm_OUT is tied low.
module temp_sensor_reader #(
  parameter int C_CHANNELS            = 4,
  parameter int C_TEMP_SENSOR_PO_WL   = 16,
  parameter int C_TEMP_SENSOR_DATA_WL = 13,
  parameter int C_SCK_DIV             = 4,
  parameter int C_CS_SETUP            = 8
) (
  input  logic                                        CLK_IN,
  input  logic                                        RST_IN,
  input  logic                                        Start_IN,
  input  logic                                        Scan_mode_IN,
  input  logic                                        Temp_sensor_SO_IN,
  output logic                                        Temp_sensor_SCK_OUT,
  output logic [C_CHANNELS-1:0]                       Temp_sensor_CS_OUT,
  output logic [C_CHANNELS*C_TEMP_SENSOR_DATA_WL-1:0] Temp_data_OUT,
  output logic                                        Data_valid_OUT,
  output logic [2:0]                                  Channel_OUT,
  output logic [C_CHANNELS-1:0]                       Fault_OUT,
  input  logic [C_TEMP_SENSOR_DATA_WL-1:0]            Alarm_threshold_IN,
  output logic [C_CHANNELS-1:0]                       Alarm_OUT,
  output logic                                        Busy_OUT
);

  localparam int PO_WL   = C_TEMP_SENSOR_PO_WL;
  localparam int DATA_WL = C_TEMP_SENSOR_DATA_WL;
  // The sensor reports its open/short fault in frame bit 2.
  localparam int FAULT_BIT = 2;

  // One phase counter serves both the SCK half-periods and the setup/gap waits.
  localparam int CNT_MAX = (C_SCK_DIV > C_CS_SETUP) ? C_SCK_DIV : C_CS_SETUP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(PO_WL + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(C_CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(C_SCK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(PO_WL - 1);
  localparam logic [2:0]       CH_LAST    = 3'(C_CHANNELS - 1);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SCK_HIGH,
    SCK_LOW,
    GAP,
    STORE
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [BIT_W-1:0]   bit_reg, bit_next;
  logic [2:0]         ch_reg, ch_next;
  logic [PO_WL-1:0]   shift_reg;
  logic               sck_reg, sck_next;
  logic [C_CHANNELS-1:0] cs_reg, cs_next;
  logic               valid_reg;
  logic [2:0]         channel_reg;

  logic               active_next;
  logic               shift_en;
  logic               store_en;
  logic [DATA_WL-1:0] frame_data;
  logic               frame_fault;

  logic [DATA_WL-1:0] temp_reg  [C_CHANNELS];
  logic               fault_reg [C_CHANNELS];

  // Next-state logic: phase timing, bit counting and channel sequencing
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    bit_next   = bit_reg;
    ch_next    = ch_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        bit_next = '0;
        if (Start_IN || Scan_mode_IN) begin
          state_next = CS_SETUP;
          ch_next    = '0;
        end
      end
      CS_SETUP: begin
        if (cnt_reg == SETUP_LAST) begin
          state_next = SCK_HIGH;
          cnt_next   = '0;
        end
      end
      SCK_HIGH: begin
        if (cnt_reg == HALF_LAST) begin
          state_next = SCK_LOW;
          cnt_next   = '0;
        end
      end
      SCK_LOW: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next = '0;
          if (bit_reg == BIT_LAST) begin
            state_next = GAP;
            bit_next   = '0;
          end else begin
            state_next = SCK_HIGH;
            bit_next   = bit_reg + 1'b1;
          end
        end
      end
      GAP: begin
        if (cnt_reg == SETUP_LAST) begin
          state_next = STORE;
          cnt_next   = '0;
        end
      end
      STORE: begin
        cnt_next = '0;
        if (ch_reg == CH_LAST) begin
          // Scan mode is sampled only here, so dropping it mid-sweep still
          // lets the sweep finish on the last channel.
          ch_next    = '0;
          state_next = Scan_mode_IN ? CS_SETUP : IDLE;
        end else begin
          ch_next    = ch_reg + 3'd1;
          state_next = CS_SETUP;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        bit_next   = '0;
        ch_next    = '0;
      end
    endcase
  end

  // Pins are decoded from the next state so they change on the same edge as
  // the state register and leave the block glitch-free.
  assign active_next = (state_next == CS_SETUP) || (state_next == SCK_HIGH) ||
                       (state_next == SCK_LOW);
  assign sck_next    = (state_next == SCK_HIGH);
  assign shift_en    = (state_next == SCK_HIGH) && (state_reg != SCK_HIGH);
  assign store_en    = (state_next == STORE) && (state_reg != STORE);

  // The temperature field sits in the frame MSBs.
  assign frame_data  = shift_reg[PO_WL-1 -: DATA_WL];
  assign frame_fault = shift_reg[FAULT_BIT];

  // State register, counters, serial pins, shift register and the valid strobe
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_reg     <= '0;
      ch_reg      <= '0;
      sck_reg     <= 1'b0;
      cs_reg      <= '1;
      shift_reg   <= '0;
      valid_reg   <= 1'b0;
      channel_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      ch_reg    <= ch_next;
      sck_reg   <= sck_next;
      cs_reg    <= cs_next;
      if (shift_en) begin
        shift_reg <= {shift_reg[PO_WL-2:0], Temp_sensor_SO_IN};
      end
      valid_reg <= store_en;
      if (store_en) begin
        channel_reg <= ch_reg;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < C_CHANNELS; gi++) begin : g_chan
      logic hit;
      assign hit = store_en && (ch_reg == 3'(gi));

      // Only the channel currently being sequenced may pull its select low.
      assign cs_next[gi] = ~(active_next && (ch_next == 3'(gi)));

      // Capture the finished frame into this channel's reading and fault flag
      always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
          temp_reg[gi]  <= '0;
          fault_reg[gi] <= 1'b0;
        end else if (hit) begin
          temp_reg[gi]  <= frame_data;
          fault_reg[gi] <= frame_fault;
        end
      end

      assign Temp_data_OUT[gi*DATA_WL +: DATA_WL] = temp_reg[gi];
      assign Fault_OUT[gi]                        = fault_reg[gi];
    end
  endgenerate

`ifdef TEMP_SENSOR_ALARM_EN
  logic alarm_hit;
  logic alarm_reg [C_CHANNELS];

  // Both operands are two's complement, so the comparison must be signed.
  assign alarm_hit = $signed(frame_data) > $signed(Alarm_threshold_IN);

  generate
    for (genvar gi = 0; gi < C_CHANNELS; gi++) begin : g_alarm
      // Refresh the over-temperature flag together with the reading
      always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
          alarm_reg[gi] <= 1'b0;
        end else if (store_en && (ch_reg == 3'(gi))) begin
          alarm_reg[gi] <= alarm_hit;
        end
      end
      assign Alarm_OUT[gi] = alarm_reg[gi];
    end
  endgenerate
`else
  // The comparator is not built, so the threshold input is ignored.
  logic unused_alarm_threshold;
  assign unused_alarm_threshold = ^Alarm_threshold_IN;
  assign Alarm_OUT              = '0;
`endif

  assign Temp_sensor_SCK_OUT = sck_reg;
  assign Temp_sensor_CS_OUT  = cs_reg;
  assign Data_valid_OUT      = valid_reg;
  assign Channel_OUT         = channel_reg;
  assign Busy_OUT            = (state_reg != IDLE);

endmodule
